// File: rtl/axi_ram_slave_if.sv
// AXI4 bus bundle between the DDR3 controller and its RAM-backed responder.
// One transaction stream: AW/W/B for writes, AR/R for reads.
interface axi_ram_slave_if #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 responder backed by on-chip RAM; stand-in for the DDR3 MIG.
// One transaction at a time, INCR/FIXED bursts up to 256 beats.
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic           clk,
  input  logic           rst,
  axi_ram_slave_if.slave s_axi,
  output logic           wlast_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [DEPTH_LOG2-1:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE, WDATA, WRESP, RFETCH, RSEND
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            len_q, len_d;
  logic                  fixed_q, fixed_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic                  last;
  logic                  w_hs;
  logic [DEPTH_LOG2-1:0] idx_nxt;

  // Address bits outside the word index only alias.
  logic unused;
  assign unused = ^{s_axi.awaddr[ADDR_WIDTH-1:DEPTH_LOG2+5],
                    s_axi.awaddr[4:0],
                    s_axi.araddr[ADDR_WIDTH-1:DEPTH_LOG2+5],
                    s_axi.araddr[4:0]};

  assign last    = (cnt_q == len_q);
  assign idx_nxt = fixed_q ? idx_q : idx_q + ONE;
  assign w_hs    = ~rst & (state_q == WDATA) & s_axi.wvalid;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    fixed_d = fixed_q;
    bid_d   = bid_q;
    rid_d   = rid_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (s_axi.arvalid) begin
          state_d = RFETCH;
          idx_d   = s_axi.araddr[DEPTH_LOG2+4:5];
          len_d   = s_axi.arlen;
          fixed_d = (s_axi.arburst == 2'b00);
          rid_d   = s_axi.arid;
          cnt_d   = '0;
        end else if (s_axi.awvalid) begin
          state_d = WDATA;
          idx_d   = s_axi.awaddr[DEPTH_LOG2+4:5];
          len_d   = s_axi.awlen;
          fixed_d = (s_axi.awburst == 2'b00);
          bid_d   = s_axi.awid;
          cnt_d   = '0;
        end
      end
      WDATA: begin
        if (s_axi.wvalid) begin
          if (s_axi.wlast != last) err_d = 1'b1;
          idx_d = idx_nxt;
          cnt_d = cnt_q + 8'd1;
          if (last) state_d = WRESP;
        end
      end
      WRESP: begin
        if (s_axi.bready) state_d = IDLE;
      end
      RFETCH: state_d = RSEND;
      RSEND: begin
        if (s_axi.rready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_nxt;
            cnt_d   = cnt_q + 8'd1;
            state_d = RFETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      fixed_q <= 1'b0;
      bid_q   <= '0;
      rid_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      fixed_q <= fixed_d;
      bid_q   <= bid_d;
      rid_q   <= rid_d;
      err_q   <= err_d;
    end
  end

  // Byte-enable write port; array is never reset.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int i = 0; i < NB; i++) begin
        if (s_axi.wstrb[i]) mem[idx_q][8*i +: 8] <= s_axi.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (state_q == RFETCH) rdata_q <= mem[idx_q];
  end

  assign s_axi.arready = ~rst & (state_q == IDLE);
  assign s_axi.awready = ~rst & (state_q == IDLE) & ~s_axi.arvalid;
  assign s_axi.wready  = (state_q == WDATA);
  assign s_axi.bvalid  = (state_q == WRESP);
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.rvalid  = (state_q == RSEND);
  assign s_axi.rlast   = (state_q == RSEND) & last;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;
  assign wlast_err     = err_q;

endmodule
